calc3_port_issuer: RTL and testbench

CALC3_PORT_ISSUER -- requirements
Module: calc3_port_issuer

---
 rtl/calc3_port_issuer.sv | 164 ++++++++++++++++
 tb/tb_calc3_port_issuer.sv | 278 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/calc3_port_issuer.sv
// calc3_port_issuer: issues requests to a single calc3 port using four tags,
// tracks each tag (FREE -> ISSUED -> DONE -> FREE) and returns responses
// through a 4-entry completion FIFO in arrival order.
//
// Handshakes: a transfer happens at a rising edge where valid and ready are
// both 1. The request side uses req_valid/req_ready and the completion side
// uses cpl_valid/cpl_ready. Payloads are held stable while valid=1 and
// ready=0, and ready never depends on valid.
module calc3_port_issuer (
    input  logic        c_clk,
    input  logic        rst,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic [3:0]  req_cmd,
    input  logic [3:0]  req_d1,
    input  logic [3:0]  req_d2,
    input  logic [3:0]  req_r1,
    input  logic [31:0] req_data,
    output logic [3:0]  cmd,
    output logic [3:0]  d1,
    output logic [3:0]  d2,
    output logic [3:0]  r1,
    output logic [31:0] data_in,
    output logic [1:0]  tag_in,
    input  logic [31:0] data_out,
    input  logic [1:0]  resp,
    input  logic [1:0]  tag_out,
    output logic        cpl_valid,
    input  logic        cpl_ready,
    output logic [1:0]  cpl_resp,
    output logic [1:0]  cpl_tag,
    output logic [31:0] cpl_data,
    output logic [2:0]  outstanding,
    output logic        err_spurious
);

    typedef enum logic [1:0] {
        TAG_FREE   = 2'd0,
        TAG_ISSUED = 2'd1,
        TAG_DONE   = 2'd2
    } tag_state_e;

    // Per-tag state machines; readable hierarchically for debug.
    tag_state_e tag_state_q [4];
    tag_state_e tag_state_d [4];

    logic [35:0] fifo_q [4];
    logic [1:0]  wr_ptr_q, rd_ptr_q;
    logic [2:0]  count_q;

    logic [3:0]  cmd_q, cmd_d, d1_q, d1_d, d2_q, d2_d, r1_q, r1_d;
    logic [31:0] data_q, data_d;
    logic [1:0]  tag_q, tag_d;
    logic        err_q;

    logic        any_free;
    logic [1:0]  alloc_tag;
    logic        accept, issue, push, pop, rsp_hit, rsp_spur;
    logic [35:0] head;
    logic [2:0]  busy_cnt;

    // Lowest-numbered FREE tag and the count of tags in use.
    always_comb begin
        any_free  = 1'b0;
        alloc_tag = 2'd0;
        busy_cnt  = 3'd0;
        for (int i = 3; i >= 0; i--) begin
            if (tag_state_q[i] == TAG_FREE) begin
                any_free  = 1'b1;
                alloc_tag = 2'(i);
            end else begin
                busy_cnt = busy_cnt + 3'd1;
            end
        end
    end

    assign req_ready = rst & any_free;
    assign accept    = req_valid & req_ready;
    // A zero command is consumed without touching a tag or the port.
    assign issue     = accept & (req_cmd != 4'd0);

    assign head      = fifo_q[rd_ptr_q];
    assign cpl_valid = (count_q != 3'd0);
    assign pop       = cpl_valid & cpl_ready;
    assign rsp_hit   = (resp != 2'd0) && (tag_state_q[tag_out] == TAG_ISSUED);
    assign rsp_spur  = (resp != 2'd0) && !rsp_hit;
    assign push      = rsp_hit;

    // Tag transitions; a popped tag is DONE so it cannot collide with the
    // responding (ISSUED) tag or the allocated (FREE) tag in the same edge.
    always_comb begin
        for (int i = 0; i < 4; i++) begin
            tag_state_d[i] = tag_state_q[i];
        end
        if (pop)     tag_state_d[head[33:32]] = TAG_FREE;
        if (rsp_hit) tag_state_d[tag_out]     = TAG_DONE;
        if (issue)   tag_state_d[alloc_tag]   = TAG_ISSUED;
    end

    // Port drive for the cycle after an accept; zero otherwise.
    always_comb begin
        cmd_d  = 4'd0;
        d1_d   = 4'd0;
        d2_d   = 4'd0;
        r1_d   = 4'd0;
        data_d = 32'd0;
        tag_d  = 2'd0;
        if (issue) begin
            cmd_d  = req_cmd;
            d1_d   = req_d1;
            d2_d   = req_d2;
            r1_d   = req_r1;
            data_d = req_data;
            tag_d  = alloc_tag;
        end
    end

    // Tag state, FIFO pointers, port registers and error pulse.
    always_ff @(posedge c_clk) begin
        if (!rst) begin
            for (int i = 0; i < 4; i++) tag_state_q[i] <= TAG_FREE;
            wr_ptr_q <= 2'd0;
            rd_ptr_q <= 2'd0;
            count_q  <= 3'd0;
            cmd_q    <= 4'd0;
            d1_q     <= 4'd0;
            d2_q     <= 4'd0;
            r1_q     <= 4'd0;
            data_q   <= 32'd0;
            tag_q    <= 2'd0;
            err_q    <= 1'b0;
        end else begin
            for (int i = 0; i < 4; i++) tag_state_q[i] <= tag_state_d[i];
            if (push) wr_ptr_q <= wr_ptr_q + 2'd1;
            if (pop)  rd_ptr_q <= rd_ptr_q + 2'd1;
            count_q  <= count_q + {2'd0, push} - {2'd0, pop};
            cmd_q    <= cmd_d;
            d1_q     <= d1_d;
            d2_q     <= d2_d;
            r1_q     <= r1_d;
            data_q   <= data_d;
            tag_q    <= tag_d;
            err_q    <= rsp_spur;
        end
    end

    // Completion storage; contents are only visible while the entry is valid.
    always_ff @(posedge c_clk) begin
        if (rst && push) fifo_q[wr_ptr_q] <= {resp, tag_out, data_out};
    end

    assign cmd          = cmd_q;
    assign d1           = d1_q;
    assign d2           = d2_q;
    assign r1           = r1_q;
    assign data_in      = data_q;
    assign tag_in       = tag_q;
    assign cpl_resp     = cpl_valid ? head[35:34] : 2'd0;
    assign cpl_tag      = cpl_valid ? head[33:32] : 2'd0;
    assign cpl_data     = cpl_valid ? head[31:0]  : 32'd0;
    assign outstanding  = busy_cnt;
    assign err_spurious = err_q;

endmodule

// File: tb/tb_calc3_port_issuer.sv
// Bench for calc3_port_issuer: directed scenarios with a behavioural model
// (tag table + completion queue) checked every cycle, plus literal checks.
module tb_calc3_port_issuer;

    logic        c_clk, rst;
    logic        req_valid, req_ready;
    logic [3:0]  req_cmd, req_d1, req_d2, req_r1;
    logic [31:0] req_data;
    logic [3:0]  cmd, d1, d2, r1;
    logic [31:0] data_in;
    logic [1:0]  tag_in;
    logic [31:0] data_out;
    logic [1:0]  resp, tag_out;
    logic        cpl_valid, cpl_ready;
    logic [1:0]  cpl_resp, cpl_tag;
    logic [31:0] cpl_data;
    logic [2:0]  outstanding;
    logic        err_spurious;

    int n_pass = 0;
    int n_total = 0;
    logic chk_en = 1'b0;

    calc3_port_issuer dut (
        .c_clk(c_clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_cmd(req_cmd), .req_d1(req_d1), .req_d2(req_d2), .req_r1(req_r1),
        .req_data(req_data),
        .cmd(cmd), .d1(d1), .d2(d2), .r1(r1), .data_in(data_in), .tag_in(tag_in),
        .data_out(data_out), .resp(resp), .tag_out(tag_out),
        .cpl_valid(cpl_valid), .cpl_ready(cpl_ready),
        .cpl_resp(cpl_resp), .cpl_tag(cpl_tag), .cpl_data(cpl_data),
        .outstanding(outstanding), .err_spurious(err_spurious)
    );

    // Clock
    initial c_clk = 1'b0;
    always #5 c_clk = ~c_clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act !== exp) $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        else n_pass++;
    endtask

    // ---------------- behavioural model ----------------
    // m_busy: 0 = free, 1 = waiting for response, 2 = response queued
    int          m_busy [4];
    logic [35:0] exp_q [$];
    logic [3:0]  m_cmd, m_d1, m_d2, m_r1;
    logic [31:0] m_data;
    logic [1:0]  m_tag;
    logic        m_err;
    int          m_alloc;
    logic        m_pop;

    function automatic int free_cnt();
        int n = 0;
        for (int i = 0; i < 4; i++) if (m_busy[i] == 0) n++;
        return n;
    endfunction

    always @(posedge c_clk) begin
        m_cmd = 0; m_d1 = 0; m_d2 = 0; m_r1 = 0; m_data = 0; m_tag = 0; m_err = 0;
        if (!rst) begin
            for (int i = 0; i < 4; i++) m_busy[i] = 0;
            exp_q.delete();
        end else begin
            m_alloc = -1;
            for (int i = 3; i >= 0; i--) if (m_busy[i] == 0) m_alloc = i;
            m_pop = (exp_q.size() > 0) && cpl_ready;
            if (resp != 0) begin
                if (m_busy[tag_out] == 1) begin
                    exp_q.push_back({resp, tag_out, data_out});
                    m_busy[tag_out] = 2;
                end else begin
                    m_err = 1;
                end
            end
            if (m_pop) begin
                m_busy[exp_q[0][33:32]] = 0;
                void'(exp_q.pop_front());
            end
            if (req_valid && m_alloc >= 0 && req_cmd != 0) begin
                m_cmd = req_cmd; m_d1 = req_d1; m_d2 = req_d2; m_r1 = req_r1;
                m_data = req_data; m_tag = 2'(m_alloc);
                m_busy[m_alloc] = 1;
            end
        end
    end

    // ---------------- compare process ----------------
    always @(negedge c_clk) begin
        if (chk_en) begin
            check("req_ready", {31'd0, req_ready}, {31'd0, rst && free_cnt() > 0});
            check("cmd", {28'd0, cmd}, {28'd0, m_cmd});
            check("d1", {28'd0, d1}, {28'd0, m_d1});
            check("d2", {28'd0, d2}, {28'd0, m_d2});
            check("r1", {28'd0, r1}, {28'd0, m_r1});
            check("data_in", data_in, m_data);
            check("tag_in", {30'd0, tag_in}, {30'd0, m_tag});
            check("outstanding", {29'd0, outstanding}, 32'(4 - free_cnt()));
            check("err_spurious", {31'd0, err_spurious}, {31'd0, m_err});
            check("cpl_valid", {31'd0, cpl_valid}, {31'd0, exp_q.size() > 0});
            if (exp_q.size() > 0) begin
                check("cpl_resp", {30'd0, cpl_resp}, {30'd0, exp_q[0][35:34]});
                check("cpl_tag", {30'd0, cpl_tag}, {30'd0, exp_q[0][33:32]});
                check("cpl_data", cpl_data, exp_q[0][31:0]);
            end
        end
    end

    // ---------------- driver tasks ----------------
    task automatic step();
        @(posedge c_clk); #2;
    endtask

    task automatic send_req(input logic [3:0] c, input logic [3:0] a, input logic [3:0] b,
                            input logic [3:0] r, input logic [31:0] dat, output logic [1:0] got);
        logic accepted = 1'b0;
        req_valid = 1; req_cmd = c; req_d1 = a; req_d2 = b; req_r1 = r; req_data = dat;
        for (int i = 0; i < 50; i++) begin
            @(negedge c_clk);
            if (req_ready) begin accepted = 1'b1; break; end
        end
        if (!accepted) check("send_timeout", 32'd0, 32'd1);
        step();
        req_valid = 0; req_cmd = 0; req_d1 = 0; req_d2 = 0; req_r1 = 0; req_data = 0;
        got = tag_in;
    endtask

    task automatic respond(input logic [1:0] rc, input logic [1:0] t, input logic [31:0] dat);
        resp = rc; tag_out = t; data_out = dat;
        step();
        resp = 0; tag_out = 0; data_out = 0;
    endtask

    task automatic pop_one();
        cpl_ready = 1;
        step();
        cpl_ready = 0;
    endtask

    // Watchdog
    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    // ---------------- directed scenarios ----------------
    initial begin
        logic [1:0] t;
        logic [1:0] ord [4];
        logic [1:0] rcs [4];
        rst = 0; req_valid = 0; req_cmd = 0; req_d1 = 0; req_d2 = 0; req_r1 = 0;
        req_data = 0; resp = 0; tag_out = 0; data_out = 0; cpl_ready = 0;
        @(posedge c_clk); #1 chk_en = 1;
        step();
        check("rst_outstanding", {29'd0, outstanding}, 32'd0);
        check("rst_req_ready", {31'd0, req_ready}, 32'd0);
        check("rst_cpl_valid", {31'd0, cpl_valid}, 32'd0);
        check("rst_cpl_data", cpl_data, 32'd0);
        check("rst_cmd", {28'd0, cmd}, 32'd0);
        rst = 1;
        step();

        // Single add
        send_req(4'd1, 4'd2, 4'd3, 4'd4, 32'd0, t);
        check("add_tag", {30'd0, t}, 32'd0);
        check("add_cmd", {28'd0, cmd}, 32'd1);
        check("add_d2", {28'd0, d2}, 32'd3);
        step();
        check("add_cmd_after", {28'd0, cmd}, 32'd0);
        step(); step();
        respond(2'd1, 2'd0, 32'h0);
        check("add_cpl_valid", {31'd0, cpl_valid}, 32'd1);
        check("add_cpl_tag", {30'd0, cpl_tag}, 32'd0);
        check("add_cpl_resp", {30'd0, cpl_resp}, 32'd1);
        check("add_out_pre", {29'd0, outstanding}, 32'd1);
        pop_one();
        check("add_out_post", {29'd0, outstanding}, 32'd0);

        // Zero command consumes no tag
        send_req(4'd0, 4'd1, 4'd1, 4'd1, 32'h77, t);
        check("nop_cmd", {28'd0, cmd}, 32'd0);
        check("nop_out", {29'd0, outstanding}, 32'd0);

        // Tag exhaustion
        for (int i = 0; i < 4; i++) begin
            send_req(4'(i + 1), 4'(i), 4'(i + 1), 4'(i + 2), 32'h100 + 32'(i), t);
            check("exh_tag", {30'd0, t}, 32'(i));
        end
        check("exh_ready", {31'd0, req_ready}, 32'd0);
        check("exh_out", {29'd0, outstanding}, 32'd4);
        req_valid = 1; req_cmd = 4'd3; req_d1 = 4'd5; req_d2 = 4'd6; req_r1 = 4'd7; req_data = 32'h55;
        step(); step();
        check("exh_held", {28'd0, cmd}, 32'd0);
        respond(2'd1, 2'd2, 32'hAAAA);
        cpl_ready = 1;
        step();
        cpl_ready = 0;
        check("exh_ready_back", {31'd0, req_ready}, 32'd1);
        step();
        req_valid = 0;
        check("exh_fifth_cmd", {28'd0, cmd}, 32'd3);
        check("exh_fifth_tag", {30'd0, tag_in}, 32'd2);
        check("exh_fifth_data", data_in, 32'h55);
        req_cmd = 0; req_d1 = 0; req_d2 = 0; req_r1 = 0; req_data = 0;
        check("exh_out4", {29'd0, outstanding}, 32'd4);

        // Out-of-order responses 2,0,3,1
        ord[0] = 2'd2; ord[1] = 2'd0; ord[2] = 2'd3; ord[3] = 2'd1;
        rcs[0] = 2'd1; rcs[1] = 2'd2; rcs[2] = 2'd3; rcs[3] = 2'd1;
        for (int i = 0; i < 4; i++) respond(rcs[i], ord[i], 32'hD000 + 32'(ord[i]));
        cpl_ready = 1;
        for (int i = 0; i < 4; i++) begin
            check("ooo_tag", {30'd0, cpl_tag}, {30'd0, ord[i]});
            check("ooo_data", cpl_data, 32'hD000 + 32'(ord[i]));
            check("ooo_resp", {30'd0, cpl_resp}, {30'd0, rcs[i]});
            step();
        end
        cpl_ready = 0;
        check("ooo_out", {29'd0, outstanding}, 32'd0);

        // Spurious response on a free tag
        respond(2'd2, 2'd1, 32'hBAD);
        check("spur_err", {31'd0, err_spurious}, 32'd1);
        check("spur_cpl", {31'd0, cpl_valid}, 32'd0);
        check("spur_out", {29'd0, outstanding}, 32'd0);
        step();
        check("spur_err_end", {31'd0, err_spurious}, 32'd0);

        // Simultaneous pop, accept and response
        send_req(4'd2, 4'd1, 4'd2, 4'd3, 32'h10, t);
        check("sim_t0", {30'd0, t}, 32'd0);
        send_req(4'd2, 4'd4, 4'd5, 4'd6, 32'h11, t);
        check("sim_t1", {30'd0, t}, 32'd1);
        respond(2'd1, 2'd0, 32'hC0);
        cpl_ready = 1;
        req_valid = 1; req_cmd = 4'd5; req_d1 = 4'd9; req_d2 = 4'd8; req_r1 = 4'd7; req_data = 32'h12;
        resp = 2'd2; tag_out = 2'd1; data_out = 32'hC1;
        step();
        cpl_ready = 0; req_valid = 0; req_cmd = 0; req_d1 = 0; req_d2 = 0; req_r1 = 0; req_data = 0;
        resp = 0; tag_out = 0; data_out = 0;
        check("sim_new_tag", {30'd0, tag_in}, 32'd2);
        check("sim_new_cmd", {28'd0, cmd}, 32'd5);
        check("sim_cpl_valid", {31'd0, cpl_valid}, 32'd1);
        check("sim_cpl_tag", {30'd0, cpl_tag}, 32'd1);
        check("sim_cpl_data", cpl_data, 32'hC1);
        check("sim_out", {29'd0, outstanding}, 32'd2);
        pop_one();
        check("sim_out_after", {29'd0, outstanding}, 32'd1);

        // Reset mid-flight
        send_req(4'd1, 4'd1, 4'd1, 4'd1, 32'h20, t);
        check("rmf_t0", {30'd0, t}, 32'd0);
        send_req(4'd1, 4'd1, 4'd1, 4'd1, 32'h21, t);
        check("rmf_t1", {30'd0, t}, 32'd1);
        respond(2'd3, 2'd1, 32'hE1);
        check("rmf_out3", {29'd0, outstanding}, 32'd3);
        rst = 0;
        #1 check("rmf_ready_rst", {31'd0, req_ready}, 32'd0);
        step();
        check("rmf_out0", {29'd0, outstanding}, 32'd0);
        check("rmf_cpl0", {31'd0, cpl_valid}, 32'd0);
        rst = 1;
        step();
        respond(2'd1, 2'd0, 32'hF0);
        check("rmf_spur", {31'd0, err_spurious}, 32'd1);
        check("rmf_spur_cpl", {31'd0, cpl_valid}, 32'd0);

        repeat (3) step();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
